// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcodes, XLEN default and immediate formats
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    return (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OP_IMM) ? IMM_I :
           (opc == OPC_STORE)                     ? IMM_S :
           (opc == OPC_BRANCH)                    ? IMM_B :
           (opc == OPC_LUI || opc == OPC_AUIPC)   ? IMM_U :
           (opc == OPC_JAL)                       ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended RV32I immediate from an instruction word
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);
  imm_fmt_e fmt;
  assign fmt = imm_fmt(inst[6:0]);
  always_comb begin
    imm = (fmt == IMM_I) ? {{20{inst[31]}}, inst[31:20]} :
          (fmt == IMM_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          (fmt == IMM_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
          (fmt == IMM_U) ? {inst[31:12], 12'b0} :
          (fmt == IMM_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                           '0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with writeback bypass, scoreboard stalls and a one-entry ID/EX register
module decode_stage #(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_num,
  output logic [4:0]      rs2_num,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_enable,
  input  logic [4:0]      wb_rd_num,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_num,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);
  import rv32i_pkg::*;
  logic [6:0]      opc;
  logic [4:0]      rd;
  logic            legal, use1, use2, writes_rd, stall, accept;
  logic [31:0]     pending, eff, wb_mask, set_mask, kill_mask;
  logic [XLEN-1:0] op1, op2, imm;
  assign opc     = if_inst[6:0];
  assign rd      = if_inst[11:7];
  assign rs1_num = if_inst[19:15];
  assign rs2_num = if_inst[24:20];
  assign legal = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                             OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};
  assign use1 = opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  assign use2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign writes_rd = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP})
                     && rd != 5'd0;
  imm_gen u_imm_gen (.inst(if_inst), .imm(imm));
  // A register being written back this cycle is no longer a hazard; its value comes from wb_data.
  assign wb_mask   = wb_enable ? 32'd1 << wb_rd_num : '0;
  assign eff       = pending & ~wb_mask;
  assign stall     = (use1 && eff[rs1_num]) || (use2 && eff[rs2_num]) || (writes_rd && eff[rd]);
  assign if_ready  = !rst && !flush && !stall && (!ex_valid || ex_ready);
  assign accept    = if_valid && if_ready;
  assign set_mask  = (accept && writes_rd) ? 32'd1 << rd : '0;
  assign kill_mask = (flush && ex_valid) ? 32'd1 << ex_rd_num : '0;
  assign op1 = (rs1_num == 5'd0) ? '0 : (wb_enable && wb_rd_num == rs1_num) ? wb_data : rs1_data;
  assign op2 = (rs2_num == 5'd0) ? '0 : (wb_enable && wb_rd_num == rs2_num) ? wb_data : rs2_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd_num   <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      pending <= ((pending & ~wb_mask & ~kill_mask) | set_mask) & ~32'd1;
      if (flush) ex_valid <= 1'b0;
      else if (accept) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_imm      <= imm;
        ex_rd_num   <= writes_rd ? rd : 5'd0;
        ex_opcode   <= opc;
        ex_funct3   <= if_inst[14:12];
        ex_funct7b5 <= if_inst[30];
        ex_illegal  <= !legal;
      end else if (ex_ready) ex_valid <= 1'b0;
    end
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the TinyRisc-V core, sitting between fetch and execute and directly in front of `regfile`. It accepts RV32I instructions over a valid/ready handshake and drives `regfile`'s `rs1_num`/`rs2_num` read ports. It forwards same-cycle writeback data, tracks pending destination registers in a scoreboard, and stalls on hazards. Decoded operands, the immediate and control fields go into a one-entry ID/EX output register consumed by execute.

## Interface
- `XLEN`, 32, data/PC width
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `if_valid`  in  1  fetch presents an instruction
- `if_ready`  out  1  decode accepts this cycle
- `if_inst`  in  32  instruction word
- `if_pc`  in  XLEN  instruction PC
- `rs1_num`, `rs2_num`  out  5  regfile read addresses, combinational from `if_inst[19:15]` and `if_inst[24:20]`
- `rs1_data`, `rs2_data`  in  XLEN  regfile read data, combinational
- `wb_enable`  in  1  writeback commits this cycle (same signal as regfile `w_enable`)
- `wb_rd_num`  in  5  writeback destination
- `wb_data`  in  XLEN  writeback value
- `flush`  in  1  execute redirect; kill the ID/EX entry
- `ex_valid`  out  1  ID/EX entry valid
- `ex_ready`  in  1  execute consumes the entry
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN  registered operands and sign-extended immediate
- `ex_rd_num`  out  5  destination; 0 if the instruction has no write
- `ex_opcode`  out  7, `ex_funct3`  out  3, `ex_funct7b5`  out  1  registered control fields
- `ex_illegal`  out  1  opcode is not RV32I base

## Operation
- Source use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- Register write: `writes_rd` is true for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- Immediate: I/S/B/U/J formats, sign-extended to XLEN. U-type is `inst[31:12]<<12`. All others give 0.
- Scoreboard: `pending[31:0]`, bit 0 is hardwired 0.
  - Clear: bit `wb_rd_num` clears when `wb_enable` is high.
  - Set: bit rd sets when an instruction with `writes_rd` is accepted.
  - If set and clear hit the same bit in the same cycle, set wins.
- Effective pending: `eff = pending & ~(wb_enable ? 1<<wb_rd_num : 0)`.
- Stall: asserted when a used source or the rd of a `writes_rd` instruction has its `eff` bit set. Including rd (WAW) keeps each bit single-owner.
- Bypass: if `wb_enable` and `wb_rd_num` == a used source (nonzero), that operand takes `wb_data` instead of the regfile value. The regfile write lands only at the clock edge, so bypass is required.
- Operand for source x0 is always 0.
- `if_ready = !rst && !flush && !stall && (!ex_valid || ex_ready)`.
- Accept: on `if_valid && if_ready` the ID/EX register loads and `ex_valid` is 1 next cycle.
- Drain: `ex_valid && ex_ready` with no accept gives `ex_valid` 0 next cycle.
- Hold: `ex_valid && !ex_ready` keeps all `ex_*` outputs unchanged.
- Flush: `ex_valid` goes 0 next cycle, no accept happens, and the scoreboard bit of the killed entry (`ex_rd_num`, if nonzero and valid) clears. Writeback in the same cycle is still applied.
- Illegal opcode: accepted normally, with `ex_illegal`=1, `writes_rd`=0 and no scoreboard set.

## Timing
- Reset: `ex_valid`=0, all `ex_*` data/control=0, `pending`=0, `if_ready`=0 while `rst` is high.
- Reset mid-operation discards the ID/EX entry and all pending bits on the next edge.
- Latency: 1 cycle from accept to `ex_valid`. Full throughput of 1 instruction/cycle when there is no hazard and `ex_ready`=1.
- Stall release: a stall resolves in the same cycle that writeback of the blocking register occurs. `if_ready` rises combinationally with `wb_enable`.
- `rs1_num`/`rs2_num` follow `if_inst` regardless of `if_valid`.

## Structure
- Package `rv32i_pkg` holds:
  - opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP;
  - the XLEN default;
  - the immediate-format enum.
- Sub-module `imm_gen`: combinational, takes `inst` and returns the XLEN immediate. Shared later with execute tests.
- Scoreboard, stall logic and the ID/EX register stay in `decode_stage`.

## Test plan
- Reset then `addi x3,x0,10` (0x00A00193) with `ex_ready`=1:
  - next cycle `ex_valid`=1, `ex_imm`=10, `ex_rd_num`=3;
  - `pending[3]`=1.
- `add x4,x3,x3` directly after the above:
  - `if_ready`=0 until a cycle with `wb_enable`=1, `wb_rd_num`=3, `wb_data`=0xA;
  - in that cycle the instruction is accepted and next cycle `ex_rs1_data`=`ex_rs2_data`=0xA.
- Hold `ex_ready`=0 with a valid entry for 5 cycles:
  - `ex_*` stable and `if_ready`=0;
  - release, then the next instruction follows in one cycle.
- `flush` while the entry is `addi x5,...`:
  - `ex_valid`=0 next cycle and `pending[5]`=0;
  - a following `add x6,x5,x0` is not stalled.
- Immediates:
  - `sw` with offset -4 gives `ex_imm`=0xFFFFFFFC;
  - `lui x1,0x12345` gives 0x12345000;
  - `jal` offset 0x800 gives 0x00000800;
  - opcode 0x7F gives `ex_illegal`=1 and `pending` unchanged.
